// File: rtl/serial_addsub_sequencer.sv
// serial_addsub_sequencer
//   Nibble-serial add/subtract engine. A single 4-bit add/subtract slice is
//   reused once per clock, LSB nibble first. The carry between nibbles is held
//   in a register, so a W-bit operation takes NIBBLES RUN cycles plus one DONE
//   cycle.
//
//   Optional build macro: SERIAL_ADDSUB_OVF_EN. It adds the ovf output, which
//   flags two's-complement signed overflow of the final result.
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  request an operation; accepted only in IDLE
//   sel    0 = A+B, 1 = A-B; sampled with start
//   A, B   W-bit operands; sampled with start
//   busy   high while the sequencer is stepping through the nibbles (RUN)
//   done   one-cycle completion pulse (DONE)
//   S      W-bit registered result, taken modulo 2^W
//   cout   carry out of the MSB; for subtract, 1 means no borrow
//   ovf    (only with SERIAL_ADDSUB_OVF_EN) signed overflow; cleared at accept
module serial_addsub_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sel,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] S,
  output logic                 cout
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic                 ovf
`endif
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]     a_r, b_r;
  logic             sel_r;
  logic             carry_r;
  logic [IDX_W-1:0] idx_r;

  logic [3:0] a_nib, b_nib;
  logic [4:0] sum;
  logic       last;

  // Nibble slice: subtraction is A + ~B + 1. The +1 enters as the initial
  // carry, which is loaded from sel at accept.
  always_comb begin
    a_nib = a_r[{idx_r, 2'b00} +: 4];
    b_nib = b_r[{idx_r, 2'b00} +: 4] ^ {4{sel_r}};
    sum   = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_r};
    last  = (idx_r == LAST_IDX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      sel_r   <= 1'b0;
      carry_r <= 1'b0;
      idx_r   <= '0;
      S       <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_r     <= A;
            b_r     <= B;
            sel_r   <= sel;
            carry_r <= sel;
            idx_r   <= '0;
            S       <= '0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf     <= 1'b0;
`endif
          end
        end
        RUN: begin
          S[{idx_r, 2'b00} +: 4] <= sum[3:0];
          carry_r                <= sum[4];
          idx_r                  <= idx_r + IDX_W'(1);
          if (last) begin
            cout <= sum[4];
`ifdef SERIAL_ADDSUB_OVF_EN
            // Carry into the MSB is recovered from the MSB sum bit; it is
            // XORed with the carry out of the MSB.
            ovf  <= (a_nib[3] ^ b_nib[3] ^ sum[3]) ^ sum[4];
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
